// File: rtl/sum_game_if.sv
// Signal bundle between the sum-game controller and its neighbours (access control, buttons, TRNG, displays).
// best_score exists only when BEST_SCORE_EN is defined.
interface sum_game_if #(
    parameter int DATA_W  = 4,
    parameter int SCORE_W = 4,
    parameter int TIME_W  = 7,
    parameter int ROUNDS  = 8
);
    localparam int ROUND_W = $clog2(ROUNDS + 1);

    logic                access_ok;
    logic                start_press;
    logic                player_press;
    logic [DATA_W-1:0]   player_data;
    logic [DATA_W-1:0]   rng_data;
    logic [TIME_W-1:0]   time_limit;
    logic                sec_pulse;

    logic [DATA_W-1:0]   bot_num;
    logic [DATA_W-1:0]   player_num;
    logic [DATA_W:0]     sum;
    logic [1:0]          sum_status;
    logic [TIME_W-1:0]   time_left;
    logic                timer_en;
    logic [ROUND_W-1:0]  round_num;
    logic [SCORE_W-1:0]  score;
    logic                game_over;
`ifdef BEST_SCORE_EN
    logic [SCORE_W-1:0]  best_score;

    modport master (
        output access_ok, start_press, player_press, player_data, rng_data, time_limit, sec_pulse,
        input  bot_num, player_num, sum, sum_status, time_left, timer_en, round_num, score,
               game_over, best_score
    );
    modport slave (
        input  access_ok, start_press, player_press, player_data, rng_data, time_limit, sec_pulse,
        output bot_num, player_num, sum, sum_status, time_left, timer_en, round_num, score,
               game_over, best_score
    );
`else
    modport master (
        output access_ok, start_press, player_press, player_data, rng_data, time_limit, sec_pulse,
        input  bot_num, player_num, sum, sum_status, time_left, timer_en, round_num, score,
               game_over
    );
    modport slave (
        input  access_ok, start_press, player_press, player_data, rng_data, time_limit, sec_pulse,
        output bot_num, player_num, sum, sum_status, time_left, timer_en, round_num, score,
               game_over
    );
`endif
endinterface

// File: rtl/sum_game_ctrl.sv
// Multi-round sum-to-target game controller: deal, play with countdown, judge, show, keep score.
// Optional BEST_SCORE_EN adds a best-score register that persists across games until reset.
module sum_game_ctrl #(
    parameter int DATA_W  = 4,
    parameter int TARGET  = 15,
    parameter int ROUNDS  = 8,
    parameter int SCORE_W = 4,
    parameter int TIME_W  = 7
) (
    input  logic     clk,
    input  logic     rst_n,
    sum_game_if.slave bus
);
    localparam int ROUND_W = $clog2(ROUNDS + 1);
    localparam logic [DATA_W:0]  TARGET_V = (DATA_W + 1)'(TARGET);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAL  = 3'd1,
        PLAY  = 3'd2,
        JUDGE = 3'd3,
        SHOW  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bot_q, bot_d;
    logic [DATA_W-1:0]   player_q, player_d;
    logic [DATA_W:0]     sum_q, sum_d;
    logic [1:0]          status_q, status_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic                timed_q, timed_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [DATA_W:0]     judge_sum;
    logic                abort;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s == {SCORE_W{1'b1}})
            return s;
        return s + 1'b1;
    endfunction

    function automatic logic [1:0] classify(input logic [DATA_W:0] s);
        if (s < TARGET_V)
            return 2'b01;
        else if (s == TARGET_V)
            return 2'b10;
        return 2'b11;
    endfunction

    assign judge_sum = {1'b0, bot_q} + {1'b0, player_q};
    // Losing access mid-game drops to IDLE but leaves the last result on the displays.
    assign abort = !bus.access_ok && (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        state_d  = state_q;
        bot_d    = bot_q;
        player_d = player_q;
        sum_d    = sum_q;
        status_d = status_q;
        time_d   = time_q;
        timed_d  = timed_q;
        round_d  = round_q;
        score_d  = score_q;
        if (abort) begin
            state_d = IDLE;
            round_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_press && bus.access_ok) begin
                        state_d = DEAL;
                        score_d = '0;
                        round_d = '0;
                    end
                end
                DEAL: begin
                    bot_d    = bus.rng_data;
                    player_d = '0;
                    sum_d    = '0;
                    status_d = 2'b00;
                    round_d  = round_q + 1'b1;
                    time_d   = bus.time_limit;
                    timed_d  = (bus.time_limit != '0);
                    state_d  = PLAY;
                end
                PLAY: begin
                    // A press always beats a simultaneous second tick.
                    if (bus.player_press) begin
                        player_d = bus.player_data;
                        state_d  = JUDGE;
                    end else if (timed_q && bus.sec_pulse && (time_q != '0)) begin
                        time_d = time_q - 1'b1;
                        if (time_q == TIME_W'(1))
                            state_d = SHOW;
                    end
                end
                JUDGE: begin
                    sum_d    = judge_sum;
                    status_d = classify(judge_sum);
                    if (classify(judge_sum) == 2'b10)
                        score_d = sat_inc(score_q);
                    state_d  = SHOW;
                end
                SHOW: begin
                    if (bus.start_press)
                        state_d = (round_q < LAST_ROUND) ? DEAL : DONE;
                end
                DONE: begin
                    if (bus.start_press && bus.access_ok) begin
                        state_d = DEAL;
                        score_d = '0;
                        round_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bot_q    <= '0;
            player_q <= '0;
            sum_q    <= '0;
            status_q <= 2'b00;
            time_q   <= '0;
            timed_q  <= 1'b0;
            round_q  <= '0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            bot_q    <= bot_d;
            player_q <= player_d;
            sum_q    <= sum_d;
            status_q <= status_d;
            time_q   <= time_d;
            timed_q  <= timed_d;
            round_q  <= round_d;
            score_q  <= score_d;
        end
    end

`ifdef BEST_SCORE_EN
    logic [SCORE_W-1:0] best_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            best_q <= '0;
        else if ((state_d == DONE) && (state_q != DONE) && (score_q > best_q))
            best_q <= score_q;
    end

    assign bus.best_score = best_q;
`endif

    assign bus.bot_num    = bot_q;
    assign bus.player_num = player_q;
    assign bus.sum        = sum_q;
    assign bus.sum_status = status_q;
    assign bus.time_left  = time_q;
    assign bus.timer_en   = (state_q == PLAY) && timed_q;
    assign bus.round_num  = round_q;
    assign bus.score      = score_q;
    assign bus.game_over  = (state_q == DONE);
endmodule
